// File: rtl/bsg_axil_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// bsg_axil_rr_arb_pkg : FSM encodings and AXI response codes for the arbiter
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bsg_axil_rr_arb_pkg;

   typedef enum logic [1:0] {
      e_w_idle = 2'd0,
      e_w_xfer = 2'd1,
      e_w_resp = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      e_r_idle = 2'd0,
      e_r_addr = 2'd1,
      e_r_data = 2'd2
   } r_state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int STAT_W = 32;

endpackage

`default_nettype wire

// File: rtl/bsg_axil_rr_arb_picker.sv
// ----------------------------------------------------------------------------
// bsg_axil_rr_arb_picker : round-robin pointer with a grant lock held until release
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_axil_rr_arb_picker
   import bsg_axil_rr_arb_pkg::*;
#(
   parameter  int num_s_p = 2,
   localparam int id_w_lp = $clog2(num_s_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [num_s_p-1:0] req_i,
   input  logic               release_i,
   output logic [id_w_lp-1:0] grant_id_o,
   output logic               grant_v_o
);

   logic [id_w_lp-1:0] ptr_q, ptr_d;
   logic [id_w_lp-1:0] grant_id_q, grant_id_d;
   logic               lock_q, lock_d;
   logic [id_w_lp-1:0] pick_id;
   logic               pick_v;
   logic [id_w_lp:0]   cand;

   // Scan cyclically from the pointer; one extra bit keeps the wrap explicit
   // for non-power-of-two requester counts.
   always_comb begin
      pick_id = ptr_q;
      pick_v  = 1'b0;
      cand    = '0;
      for (int i = 0; i < num_s_p; i++) begin
         cand = {1'b0, ptr_q} + (id_w_lp+1)'(i);
         if (cand >= (id_w_lp+1)'(num_s_p))
            cand = cand - (id_w_lp+1)'(num_s_p);
         if (!pick_v && req_i[cand[id_w_lp-1:0]]) begin
            pick_v  = 1'b1;
            pick_id = cand[id_w_lp-1:0];
         end
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      lock_d     = lock_q;
      if (release_i) begin
         lock_d = 1'b0;
         ptr_d  = (grant_id_q == id_w_lp'(num_s_p-1)) ? '0 : grant_id_q + id_w_lp'(1);
      end else if (!lock_q && pick_v) begin
         lock_d     = 1'b1;
         grant_id_d = pick_id;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q      <= '0;
         grant_id_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         lock_q     <= lock_d;
      end
   end

   assign grant_id_o = grant_id_q;
   assign grant_v_o  = lock_q;

endmodule

`default_nettype wire

// File: rtl/bsg_axil_rr_arb.sv
// ----------------------------------------------------------------------------
// bsg_axil_rr_arb : N-to-1 AXI4-Lite arbiter, independent round-robin read and
// write paths. Optional grant counters under BSG_AXIL_RR_ARB_STATS_EN. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_axil_rr_arb
   import bsg_axil_rr_arb_pkg::*;
#(
   parameter  int num_s_p       = 2,
   parameter  int addr_width_p  = 32,
   parameter  int data_width_p  = 32,
   localparam int strb_width_lp = data_width_p/8,
   localparam int id_w_lp       = $clog2(num_s_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
`ifdef BSG_AXIL_RR_ARB_STATS_EN
   output logic [num_s_p*STAT_W-1:0]         wr_grants_o,
   output logic [num_s_p*STAT_W-1:0]         rd_grants_o,
`endif
   input  logic [num_s_p*addr_width_p-1:0]   s_axi_awaddr_i,
   input  logic [num_s_p*3-1:0]              s_axi_awprot_i,
   input  logic [num_s_p-1:0]                s_axi_awvalid_i,
   output logic [num_s_p-1:0]                s_axi_awready_o,
   input  logic [num_s_p*data_width_p-1:0]   s_axi_wdata_i,
   input  logic [num_s_p*strb_width_lp-1:0]  s_axi_wstrb_i,
   input  logic [num_s_p-1:0]                s_axi_wvalid_i,
   output logic [num_s_p-1:0]                s_axi_wready_o,
   output logic [num_s_p*2-1:0]              s_axi_bresp_o,
   output logic [num_s_p-1:0]                s_axi_bvalid_o,
   input  logic [num_s_p-1:0]                s_axi_bready_i,
   input  logic [num_s_p*addr_width_p-1:0]   s_axi_araddr_i,
   input  logic [num_s_p*3-1:0]              s_axi_arprot_i,
   input  logic [num_s_p-1:0]                s_axi_arvalid_i,
   output logic [num_s_p-1:0]                s_axi_arready_o,
   output logic [num_s_p*data_width_p-1:0]   s_axi_rdata_o,
   output logic [num_s_p*2-1:0]              s_axi_rresp_o,
   output logic [num_s_p-1:0]                s_axi_rvalid_o,
   input  logic [num_s_p-1:0]                s_axi_rready_i,
   output logic [addr_width_p-1:0]           m_axi_awaddr_o,
   output logic [2:0]                        m_axi_awprot_o,
   output logic                              m_axi_awvalid_o,
   input  logic                              m_axi_awready_i,
   output logic [data_width_p-1:0]           m_axi_wdata_o,
   output logic [strb_width_lp-1:0]          m_axi_wstrb_o,
   output logic                              m_axi_wvalid_o,
   input  logic                              m_axi_wready_i,
   input  logic [1:0]                        m_axi_bresp_i,
   input  logic                              m_axi_bvalid_i,
   output logic                              m_axi_bready_o,
   output logic [addr_width_p-1:0]           m_axi_araddr_o,
   output logic [2:0]                        m_axi_arprot_o,
   output logic                              m_axi_arvalid_o,
   input  logic                              m_axi_arready_i,
   input  logic [data_width_p-1:0]           m_axi_rdata_i,
   input  logic [1:0]                        m_axi_rresp_i,
   input  logic                              m_axi_rvalid_i,
   output logic                              m_axi_rready_o
);

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic     aw_done_q, aw_done_d;
   logic     w_done_q, w_done_d;

   logic [id_w_lp-1:0] grant_w, grant_r, w_sel, r_sel;
   logic               grant_w_v, grant_r_v;
   logic               w_xfer, w_resp, r_addr, r_data;
   logic               aw_fire, w_fire, b_fire, ar_fire, r_fire;
   logic [num_s_p-1:0] w_req;

   logic [addr_width_p-1:0]  awaddr_a [num_s_p];
   logic [addr_width_p-1:0]  araddr_a [num_s_p];
   logic [2:0]               awprot_a [num_s_p];
   logic [2:0]               arprot_a [num_s_p];
   logic [data_width_p-1:0]  wdata_a  [num_s_p];
   logic [strb_width_lp-1:0] wstrb_a  [num_s_p];

   assign w_req = s_axi_awvalid_i | s_axi_wvalid_i;

   bsg_axil_rr_arb_picker #(.num_s_p(num_s_p)) u_wpick (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_i      (w_req),
      .release_i  (b_fire),
      .grant_id_o (grant_w),
      .grant_v_o  (grant_w_v)
   );

   bsg_axil_rr_arb_picker #(.num_s_p(num_s_p)) u_rpick (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_i      (s_axi_arvalid_i),
      .release_i  (r_fire),
      .grant_id_o (grant_r),
      .grant_v_o  (grant_r_v)
   );

   assign w_xfer = (w_state_q == e_w_xfer) && grant_w_v;
   assign w_resp = (w_state_q == e_w_resp);
   assign r_addr = (r_state_q == e_r_addr) && grant_r_v;
   assign r_data = (r_state_q == e_r_data);

   // Idle paths park the payload muxes on requester 0.
   assign w_sel = (w_state_q == e_w_idle) ? '0 : grant_w;
   assign r_sel = (r_state_q == e_r_idle) ? '0 : grant_r;

   genvar k;
   generate
      for (k = 0; k < num_s_p; k++) begin : g_port
         assign awaddr_a[k] = s_axi_awaddr_i[k*addr_width_p +: addr_width_p];
         assign araddr_a[k] = s_axi_araddr_i[k*addr_width_p +: addr_width_p];
         assign awprot_a[k] = s_axi_awprot_i[k*3 +: 3];
         assign arprot_a[k] = s_axi_arprot_i[k*3 +: 3];
         assign wdata_a[k]  = s_axi_wdata_i[k*data_width_p +: data_width_p];
         assign wstrb_a[k]  = s_axi_wstrb_i[k*strb_width_lp +: strb_width_lp];

         assign s_axi_awready_o[k] = w_xfer && !aw_done_q && (grant_w == id_w_lp'(k)) && m_axi_awready_i;
         assign s_axi_wready_o[k]  = w_xfer && !w_done_q  && (grant_w == id_w_lp'(k)) && m_axi_wready_i;
         assign s_axi_bvalid_o[k]  = w_resp && (grant_w == id_w_lp'(k)) && m_axi_bvalid_i;
         assign s_axi_arready_o[k] = r_addr && (grant_r == id_w_lp'(k)) && m_axi_arready_i;
         assign s_axi_rvalid_o[k]  = r_data && (grant_r == id_w_lp'(k)) && m_axi_rvalid_i;

         assign s_axi_bresp_o[k*2 +: 2]                    = m_axi_bresp_i;
         assign s_axi_rresp_o[k*2 +: 2]                    = m_axi_rresp_i;
         assign s_axi_rdata_o[k*data_width_p +: data_width_p] = m_axi_rdata_i;
      end
   endgenerate

   assign m_axi_awaddr_o  = awaddr_a[w_sel];
   assign m_axi_awprot_o  = awprot_a[w_sel];
   assign m_axi_wdata_o   = wdata_a[w_sel];
   assign m_axi_wstrb_o   = wstrb_a[w_sel];
   assign m_axi_araddr_o  = araddr_a[r_sel];
   assign m_axi_arprot_o  = arprot_a[r_sel];

   assign m_axi_awvalid_o = w_xfer && !aw_done_q && s_axi_awvalid_i[grant_w];
   assign m_axi_wvalid_o  = w_xfer && !w_done_q  && s_axi_wvalid_i[grant_w];
   assign m_axi_bready_o  = w_resp && s_axi_bready_i[grant_w];
   assign m_axi_arvalid_o = r_addr && s_axi_arvalid_i[grant_r];
   assign m_axi_rready_o  = r_data && s_axi_rready_i[grant_r];

   assign aw_fire = m_axi_awvalid_o && m_axi_awready_i;
   assign w_fire  = m_axi_wvalid_o  && m_axi_wready_i;
   assign b_fire  = m_axi_bvalid_i  && m_axi_bready_o;
   assign ar_fire = m_axi_arvalid_o && m_axi_arready_i;
   assign r_fire  = m_axi_rvalid_i  && m_axi_rready_o;

   // AW and W complete independently; RESP waits for both.
   always_comb begin
      w_state_d = w_state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (w_state_q)
         e_w_idle: if (|w_req) w_state_d = e_w_xfer;
         e_w_xfer: begin
            aw_done_d = aw_done_q | aw_fire;
            w_done_d  = w_done_q  | w_fire;
            if (aw_done_d && w_done_d) w_state_d = e_w_resp;
         end
         e_w_resp: if (b_fire) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = e_w_idle;
         end
         default: w_state_d = e_w_idle;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         e_r_idle: if (|s_axi_arvalid_i) r_state_d = e_r_addr;
         e_r_addr: if (ar_fire) r_state_d = e_r_data;
         e_r_data: if (r_fire) r_state_d = e_r_idle;
         default:  r_state_d = e_r_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_state_q <= e_w_idle;
         r_state_q <= e_r_idle;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

`ifdef BSG_AXIL_RR_ARB_STATS_EN
   logic [STAT_W-1:0] wr_cnt_q [num_s_p];
   logic [STAT_W-1:0] wr_cnt_d [num_s_p];
   logic [STAT_W-1:0] rd_cnt_q [num_s_p];
   logic [STAT_W-1:0] rd_cnt_d [num_s_p];

   // Saturating per-requester completion counters.
   always_comb begin
      for (int i = 0; i < num_s_p; i++) begin
         wr_cnt_d[i] = wr_cnt_q[i];
         rd_cnt_d[i] = rd_cnt_q[i];
         if (b_fire && (grant_w == id_w_lp'(i)) && (wr_cnt_q[i] != '1))
            wr_cnt_d[i] = wr_cnt_q[i] + STAT_W'(1);
         if (r_fire && (grant_r == id_w_lp'(i)) && (rd_cnt_q[i] != '1))
            rd_cnt_d[i] = rd_cnt_q[i] + STAT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < num_s_p; i++) begin
         if (reset_i) begin
            wr_cnt_q[i] <= '0;
            rd_cnt_q[i] <= '0;
         end else begin
            wr_cnt_q[i] <= wr_cnt_d[i];
            rd_cnt_q[i] <= rd_cnt_d[i];
         end
      end
   end

   generate
      for (k = 0; k < num_s_p; k++) begin : g_stats
         assign wr_grants_o[k*STAT_W +: STAT_W] = wr_cnt_q[k];
         assign rd_grants_o[k*STAT_W +: STAT_W] = rd_cnt_q[k];
      end
   endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_axil_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_bsg_axil_rr_arb : directed self-checking bench, two requesters. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bsg_axil_rr_arb;
   import bsg_axil_rr_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_i;

   logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [5:0]  s_awprot, s_arprot;
   logic [7:0]  s_wstrb;
   logic [3:0]  s_bresp, s_rresp;
   logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;

   logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;

`ifdef BSG_AXIL_RR_ARB_STATS_EN
   logic [63:0] wr_grants, rd_grants;
`endif

   int n_run  = 0;
   int n_fail = 0;
   int aw_hs  = 0;
   int aw0;

   always #5 clk = ~clk;

   always @(posedge clk) if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;

   bsg_axil_rr_arb dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
`ifdef BSG_AXIL_RR_ARB_STATS_EN
      .wr_grants_o     (wr_grants),
      .rd_grants_o     (rd_grants),
`endif
      .s_axi_awaddr_i  (s_awaddr),
      .s_axi_awprot_i  (s_awprot),
      .s_axi_awvalid_i (s_awvalid),
      .s_axi_awready_o (s_awready),
      .s_axi_wdata_i   (s_wdata),
      .s_axi_wstrb_i   (s_wstrb),
      .s_axi_wvalid_i  (s_wvalid),
      .s_axi_wready_o  (s_wready),
      .s_axi_bresp_o   (s_bresp),
      .s_axi_bvalid_o  (s_bvalid),
      .s_axi_bready_i  (s_bready),
      .s_axi_araddr_i  (s_araddr),
      .s_axi_arprot_i  (s_arprot),
      .s_axi_arvalid_i (s_arvalid),
      .s_axi_arready_o (s_arready),
      .s_axi_rdata_o   (s_rdata),
      .s_axi_rresp_o   (s_rresp),
      .s_axi_rvalid_o  (s_rvalid),
      .s_axi_rready_i  (s_rready),
      .m_axi_awaddr_o  (m_awaddr),
      .m_axi_awprot_o  (m_awprot),
      .m_axi_awvalid_o (m_awvalid),
      .m_axi_awready_i (m_awready),
      .m_axi_wdata_o   (m_wdata),
      .m_axi_wstrb_o   (m_wstrb),
      .m_axi_wvalid_o  (m_wvalid),
      .m_axi_wready_i  (m_wready),
      .m_axi_bresp_i   (m_bresp),
      .m_axi_bvalid_i  (m_bvalid),
      .m_axi_bready_o  (m_bready),
      .m_axi_araddr_o  (m_araddr),
      .m_axi_arprot_o  (m_arprot),
      .m_axi_arvalid_o (m_arvalid),
      .m_axi_arready_i (m_arready),
      .m_axi_rdata_i   (m_rdata),
      .m_axi_rresp_i   (m_rresp),
      .m_axi_rvalid_i  (m_rvalid),
      .m_axi_rready_o  (m_rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered at an IDLE negedge with the requests already driven.
   task automatic do_write(input int id, input logic [31:0] addr);
      @(negedge clk); #1;
      chk("wr_awaddr", m_awaddr, addr);
      chk("wr_awready", s_awready, 64'd1 << id);
      @(negedge clk);
      m_bvalid = 1'b1;
      #1;
      chk("wr_bvalid", s_bvalid, 64'd1 << id);
      @(negedge clk);
      m_bvalid = 1'b0;
   endtask

   task automatic do_read(input int id, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk); #1;
      chk("rd_araddr", m_araddr, addr);
      chk("rd_arready", s_arready, 64'd1 << id);
      @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = data;
      #1;
      chk("rd_rvalid", s_rvalid, 64'd1 << id);
      chk("rd_rdata", s_rdata[id*32 +: 32], data);
      @(negedge clk);
      m_rvalid = 1'b0;
   endtask

   initial begin
      reset_i   = 1'b1;
      s_awaddr  = '0; s_araddr = '0; s_wdata = '0; s_awprot = '0; s_arprot = '0;
      s_wstrb   = 8'hFF;
      s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
      s_bready  = 2'b11; s_rready = 2'b11;
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      m_bvalid  = 1'b0; m_bresp = OKAY; m_rvalid = 1'b0; m_rresp = OKAY; m_rdata = '0;

      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk("rst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                       s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 64'd0);

      // Single s0 write: one-cycle arbitration latency, B three cycles later.
      @(negedge clk);
      s_awvalid = 2'b01; s_wvalid = 2'b01;
      s_awaddr[31:0] = 32'h10; s_wdata[31:0] = 32'hCAFE_0010;
      #1;
      chk("t1_awvalid_lat", m_awvalid, 0);
      @(negedge clk); #1;
      chk("t1_awvalid", m_awvalid, 1);
      chk("t1_awaddr", m_awaddr, 32'h10);
      chk("t1_wdata", m_wdata, 32'hCAFE_0010);
      chk("t1_awready", s_awready, 2'b01);
      chk("t1_wready", s_wready, 2'b01);
      @(negedge clk);
      s_awvalid = 2'b00; s_wvalid = 2'b00;
      #1;
      chk("t1_no_bvalid", s_bvalid, 0);
      chk("t1_awvalid_off", m_awvalid, 0);
      @(negedge clk);
      @(negedge clk);
      m_bvalid = 1'b1; m_bresp = OKAY;
      #1;
      chk("t1_bvalid", s_bvalid, 2'b01);
      chk("t1_bready", m_bready, 1);
      @(negedge clk);
      m_bvalid = 1'b0;

      // Pointer now at 1: simultaneous s0/s1 writes grant s1 first.
      s_awvalid = 2'b11; s_wvalid = 2'b11;
      s_awaddr  = {32'h14, 32'h10};
      do_write(1, 32'h14);
      do_write(0, 32'h10);
      s_awvalid = 2'b00; s_wvalid = 2'b00;

      // Continuous reads from both requesters alternate.
      s_arvalid = 2'b11;
      s_araddr  = {32'h200, 32'h100};
      for (int t = 0; t < 6; t++)
         do_read(t % 2, (t % 2) ? 32'h200 : 32'h100, 32'hA000 + t);
      s_arvalid = 2'b00;

      // s1 presents W four cycles ahead of AW.
      aw0 = aw_hs;
      s_wvalid = 2'b10; s_wdata[63:32] = 32'h1234;
      @(negedge clk); #1;
      chk("t3_wvalid", m_wvalid, 1);
      chk("t3_wready", s_wready, 2'b10);
      chk("t3_awvalid_wait", m_awvalid, 0);
      @(negedge clk); #1;
      chk("t3_w_gated", m_wvalid, 0);
      chk("t3_wready_gated", s_wready, 0);
      @(negedge clk);
      @(negedge clk);
      s_awvalid = 2'b10; s_awaddr[63:32] = 32'h40;
      #1;
      chk("t3_awvalid", m_awvalid, 1);
      chk("t3_awaddr", m_awaddr, 32'h40);
      chk("t3_awready", s_awready, 2'b10);
      @(negedge clk);
      s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
      #1;
      chk("t3_bvalid", s_bvalid, 2'b10);
      @(negedge clk);
      m_bvalid = 1'b0;
      chk("t3_aw_once", aw_hs - aw0, 1);

      // Concurrent s0 read and s1 write.
      s_arvalid = 2'b01; s_araddr[31:0] = 32'h20;
      s_awvalid = 2'b10; s_wvalid = 2'b10; s_awaddr[63:32] = 32'h30;
      #1;
      chk("t4_lat", {m_arvalid, m_awvalid}, 0);
      @(negedge clk); #1;
      chk("t4_both_valid", {m_arvalid, m_awvalid}, 2'b11);
      chk("t4_araddr", m_araddr, 32'h20);
      chk("t4_awaddr", m_awaddr, 32'h30);
      @(negedge clk);
      s_arvalid = 2'b00; s_awvalid = 2'b00; s_wvalid = 2'b00;
      m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA; m_bvalid = 1'b1; m_bresp = SLVERR;
      #1;
      chk("t4_rvalid", s_rvalid, 2'b01);
      chk("t4_rdata", s_rdata[31:0], 32'h5555_AAAA);
      chk("t4_bvalid", s_bvalid, 2'b10);
      chk("t4_bresp", s_bresp, 4'b1010);
      @(negedge clk);
      m_rvalid = 1'b0; m_bvalid = 1'b0; m_bresp = OKAY;

      // Reset while the write path holds a pending B.
      s_awvalid = 2'b01; s_wvalid = 2'b01; s_awaddr[31:0] = 32'h60;
      @(negedge clk);
      @(negedge clk);
      s_awvalid = 2'b00; s_wvalid = 2'b00; s_bready = 2'b00; m_bvalid = 1'b1;
      #1;
      chk("t5_pending", {s_bvalid, m_bready}, 3'b010);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0; s_bready = 2'b11;
      #1;
      chk("t5_rst_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                          s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 64'd0);
      m_bvalid = 1'b0;
      s_awvalid = 2'b10; s_wvalid = 2'b10; s_awaddr = {32'h50, 32'h60};
      s_arvalid = 2'b11; s_araddr = {32'h208, 32'h108};
      @(negedge clk); #1;
      chk("t5_awaddr", m_awaddr, 32'h50);
      chk("t5_awready", s_awready, 2'b10);
      chk("t5_araddr", m_araddr, 32'h108);
      chk("t5_arready", s_arready, 2'b01);
      @(negedge clk);
      s_awvalid = 2'b00; s_wvalid = 2'b00; s_arvalid = 2'b00;
      m_bvalid = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
      #1;
      chk("t5_bvalid", s_bvalid, 2'b10);
      chk("t5_rvalid", s_rvalid, 2'b01);
      @(negedge clk);
      m_bvalid = 1'b0; m_rvalid = 1'b0;

`ifdef BSG_AXIL_RR_ARB_STATS_EN
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      s_awvalid = 2'b01; s_wvalid = 2'b01; s_awaddr[31:0] = 32'h70;
      for (int t = 0; t < 3; t++) do_write(0, 32'h70);
      s_awvalid = 2'b00; s_wvalid = 2'b00;
      s_arvalid = 2'b10; s_araddr[63:32] = 32'h300;
      for (int t = 0; t < 5; t++) do_read(1, 32'h300, 32'hB000 + t);
      s_arvalid = 2'b00;
      #1;
      chk("stats_wr", wr_grants, {32'd0, 32'd3});
      chk("stats_rd", rd_grants, {32'd5, 32'd0});
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bsg_axil_rr_arb.md
Name: bsg_axil_rr_arb

Overview:
- N-requester to 1-completer AXI4-Lite arbiter. It replaces the static-priority, single-outstanding sharing of the BP-side AXI-Lite port.
- Read and write paths are arbitrated independently, so one requester may read while another writes.
- Each path grants round-robin and holds the grant until the response handshake, so requesters may pipeline AW, W and AR safely.

Parameters:
- num_s_p, 2, number of requester ports (2..8).
- addr_width_p, 32, AXI-Lite address width.
- data_width_p, 32, AXI-Lite data width (32 or 64).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- s_axi_awaddr_i  in  num_s_p*addr_width_p  packed requester AW address, requester k at slice k.
- s_axi_awprot_i  in  num_s_p*3  AW prot.
- s_axi_awvalid_i / s_axi_awready_o  in/out  num_s_p  AW handshake.
- s_axi_wdata_i  in  num_s_p*data_width_p  W data.
- s_axi_wstrb_i  in  num_s_p*(data_width_p/8)  W strobe.
- s_axi_wvalid_i / s_axi_wready_o  in/out  num_s_p  W handshake.
- s_axi_bresp_o  out  num_s_p*2  B resp (broadcast).
- s_axi_bvalid_o / s_axi_bready_i  out/in  num_s_p  B handshake.
- s_axi_araddr_i  in  num_s_p*addr_width_p  AR address.
- s_axi_arprot_i  in  num_s_p*3  AR prot.
- s_axi_arvalid_i / s_axi_arready_o  in/out  num_s_p  AR handshake.
- s_axi_rdata_o  out  num_s_p*data_width_p  R data (broadcast).
- s_axi_rresp_o  out  num_s_p*2  R resp (broadcast).
- s_axi_rvalid_o / s_axi_rready_i  out/in  num_s_p  R handshake.
- m_axi_aw{addr,prot,valid}_o / m_axi_awready_i  AW master side.
- m_axi_w{data,strb,valid}_o / m_axi_wready_i  W master side.
- m_axi_b{resp,valid}_i / m_axi_bready_o  B master side.
- m_axi_ar{addr,prot,valid}_o / m_axi_arready_i  AR master side.
- m_axi_r{data,resp,valid}_i / m_axi_rready_o  R master side.

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - Both FSMs go to IDLE; both round-robin pointers go to 0.
  - All *valid_o and *ready_o outputs are 0.
  - Reset mid-transaction abandons the transaction. No response is fabricated.
- Write FSM (IDLE, XFER, RESP):
  - IDLE: write request k = awvalid[k] | wvalid[k]. If any request is set, register grant_w = first requester at or after wptr (cyclic), then go to XFER.
  - Arbitration latency: the grant is registered, so the earliest m_axi_awvalid is 1 cycle after the request appears.
  - XFER: forward the granted AW and W. Track aw_done and w_done independently; each channel's valid/ready is gated off once its done flag is set. Go to RESP when both are done (including both completing in the same cycle).
  - RESP: route m_axi_bvalid to s_axi_bvalid_o[grant_w]; m_axi_bready_o = s_axi_bready_i[grant_w]. On the B handshake: wptr = grant_w+1 mod num_s_p, clear done flags, go to IDLE.
- Read FSM (IDLE, ADDR, DATA):
  - Same as the write FSM, using arvalid, rptr and grant_r.
  - ADDR leaves on the AR handshake. DATA leaves on the R handshake.
- Ungranted requesters see ready=0 and valid=0 on every channel.
- Data/resp broadcast: B resp, R data and R resp are driven to all requesters; only the granted requester's valid is asserted.
- Master-side address/data muxes select by the registered grant. Payload is don't-care when valid is low; the implementation drives slice 0.
- Simultaneous events:
  - A read and a write from the same or different requesters proceed concurrently.
  - A grant is taken in the cycle after leaving RESP/DATA (back-to-back IDLE), giving a 1-cycle bubble between transactions.
- Fairness: a requester asserting continuously is granted at least once every num_s_p transactions on that path.
- Width rules:
  - Pointers and grants are $clog2(num_s_p) bits; the wrap is explicit for non-power-of-2 num_s_p.
  - Slices are selected with an indexed part-select of width addr_width_p or data_width_p.

Optional Feature:
- Macro: BSG_AXIL_RR_ARB_STATS_EN.
- Defined:
  - Adds output wr_grants_o and output rd_grants_o, each num_s_p*32 wide.
  - Each 32-bit counter increments on that requester's B (respectively R) handshake and saturates at 0xFFFF_FFFF.
  - Counters are cleared by reset_i.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- bsg_axil_rr_arb_pkg:
  - write FSM enum (e_w_idle, e_w_xfer, e_w_resp);
  - read FSM enum (e_r_idle, e_r_addr, e_r_data);
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
- Sub-module bsg_axil_rr_arb_picker: registered round-robin pointer plus lock. It takes a req vector and a release pulse, and produces grant_id and grant_v. It is instanced twice (write and read).

Test Plan:
- num_s_p=2, s0 writes 0x10 with AW and W in the same cycle, completer bresp=OKAY after 3 cycles -> m_axi_awvalid rises 1 cycle after the request; s0 bvalid only; s1 sees no ready; wptr becomes 1.
- s0 and s1 both assert arvalid continuously for 6 reads -> grants alternate s0,s1,s0,s1,s0,s1; rdata routed only to the matching rvalid.
- s1 asserts W 4 cycles before AW -> W is accepted first, w_done is held, the FSM waits for AW, then RESP; exactly one m_axi_awvalid handshake.
- s0 read of 0x20 concurrent with s1 write of 0x30 -> both reach the master in the same cycle; responses are routed to the correct requesters; no stall of either path.
- reset_i asserted while the write FSM is in RESP with bvalid pending -> next cycle all valids/readies are 0, both pointers are 0, and a new s1 write is granted normally.
- With BSG_AXIL_RR_ARB_STATS_EN, 3 writes from s0 and 5 reads from s1 -> wr_grants_o[31:0]=3 and rd_grants_o[63:32]=5; all other counters are 0.
